// File: rtl/ssd_score_scanner_pkg.sv
// Shared constants and helpers for the score scanner: blank code, digit
// indices, converter state encoding and the double-dabble step.
package ssd_score_scanner_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [1:0] RIGHT_UNITS = 2'd0;
  localparam logic [1:0] RIGHT_TENS  = 2'd1;
  localparam logic [1:0] LEFT_UNITS  = 2'd2;
  localparam logic [1:0] LEFT_TENS   = 2'd3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam int BIN_W = 7;
  localparam int SR_W  = 8 + BIN_W;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic logic [BIN_W-1:0] clamp99(input logic [BIN_W-1:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble iteration: correct both BCD nibbles, then shift in the next binary MSB.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] adj;
    adj = {add3_if_ge5(s[14:11]), add3_if_ge5(s[10:7]), s[6:0]};
    return {adj[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/ssd_score_scanner_if.sv
// Score/handshake/display bus between game logic and the scanner.
interface ssd_score_scanner_if;
  logic [6:0] score_l;
  logic [6:0] score_r;
  logic       update;
  logic       busy;
  logic [3:0] digit_sel;
  logic [3:0] bcd_out;

  modport master (
    output score_l, score_r, update,
    input  busy, digit_sel, bcd_out
  );

  modport slave (
    input  score_l, score_r, update,
    output busy, digit_sel, bcd_out
  );
endinterface

// File: rtl/ssd_score_scanner_bin7_to_bcd_seq.sv
// Iterative 7-bit binary to two-digit BCD converter: start loads the value,
// seven shift-add-3 cycles follow, then one COMMIT cycle presents the result with done.
import ssd_score_scanner_pkg::*;

module bin7_to_bcd_seq (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output bcd2_t            bcd
);

  logic [1:0]      state_reg;
  logic [SR_W-1:0] sr_reg;
  logic [2:0]      iter_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      iter_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sr_reg    <= {8'd0, bin};
            iter_reg  <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          sr_reg   <= dd_step(sr_reg);
          iter_reg <= iter_reg + 3'd1;
          if (iter_reg == 3'd6) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == COMMIT);
  assign bcd  = sr_reg[SR_W-1:BIN_W];

endmodule

// File: rtl/ssd_score_scanner.sv
// Seven-segment score front end: captures two scores, converts them to BCD
// and time-multiplexes the four digits with a one-hot select.
import ssd_score_scanner_pkg::*;

module ssd_score_scanner #(
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd_score_scanner_if.slave   bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic  start;
  logic  busy_l, busy_r;
  logic  done_l, done_r;
  bcd2_t bcd_l, bcd_r;

  bcd2_t   disp_l_reg, disp_r_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    sel_reg;
  logic [3:0]    bcd_reg;

  logic          wrap;
  logic [CW-1:0] cnt_next;
  logic [1:0]    idx_next;
  logic [3:0]    sel_next;
  logic [3:0]    nib_next;

  // Requests arriving mid-conversion are simply dropped, not queued.
  assign start = bus.update & ~(busy_l | busy_r);

  bin7_to_bcd_seq u_conv_l (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (clamp99(bus.score_l)),
    .busy  (busy_l),
    .done  (done_l),
    .bcd   (bcd_l)
  );

  bin7_to_bcd_seq u_conv_r (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (clamp99(bus.score_r)),
    .busy  (busy_r),
    .done  (done_r),
    .bcd   (bcd_r)
  );

  function automatic logic [3:0] tens_code(input logic [3:0] t);
    return ((BLANK_LEADING != 0) && (t == 4'd0)) ? BCD_BLANK : t;
  endfunction

  always_comb begin
    wrap     = (cnt_reg == CNT_LAST);
    cnt_next = wrap ? '0 : cnt_reg + CW'(1);
    idx_next = wrap ? idx_reg + 2'd1 : idx_reg;
    sel_next = wrap ? {sel_reg[2:0], sel_reg[3]} : sel_reg;
    nib_next = disp_r_reg.units;
    case (idx_next)
      RIGHT_UNITS: nib_next = disp_r_reg.units;
      RIGHT_TENS:  nib_next = tens_code(disp_r_reg.tens);
      LEFT_UNITS:  nib_next = disp_l_reg.units;
      LEFT_TENS:   nib_next = tens_code(disp_l_reg.tens);
      default:     nib_next = disp_r_reg.units;
    endcase
  end

  // Both scores land in the display registers on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_l_reg <= '0;
      disp_r_reg <= '0;
    end else if (done_l | done_r) begin
      disp_l_reg <= bcd_l;
      disp_r_reg <= bcd_r;
    end
  end

  // bcd_out follows the display registers every cycle, not only at slot boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= RIGHT_UNITS;
      sel_reg <= 4'b0001;
      bcd_reg <= 4'h0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      sel_reg <= sel_next;
      bcd_reg <= nib_next;
    end
  end

  assign bus.busy      = busy_l | busy_r;
  assign bus.digit_sel = sel_reg;
  assign bus.bcd_out   = bcd_reg;

endmodule

// File: tb/tb_ssd_score_scanner.sv
// Directed bench for ssd_score_scanner with blanking on (dut1) and off (dut0).
module tb_ssd_score_scanner;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ssd_score_scanner_if bus1 ();
  ssd_score_scanner_if bus0 ();

  ssd_score_scanner #(.SCAN_DIV(SD), .BLANK_LEADING(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  ssd_score_scanner #(.SCAN_DIV(SD), .BLANK_LEADING(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  sl;
    logic [6:0]  sr;
    logic [15:0] exp1;
    logic [15:0] exp0;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] l, input logic [6:0] r, input logic u);
    bus1.score_l = l; bus1.score_r = r; bus1.update = u;
    bus0.score_l = l; bus0.score_r = r; bus0.update = u;
  endtask

  // Pulse update for one cycle, then count cycles with busy high.
  task automatic convert(input logic [6:0] l, input logic [6:0] r, output int n);
    @(negedge clk);
    drive(l, r, 1'b1);
    @(negedge clk);
    drive(l, r, 1'b0);
    n = 0;
    while (bus1.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // One full rotation; digit k of the result is whatever shows while digit_sel bit k is set.
  task automatic capture(output logic [15:0] v1, output logic [15:0] v0);
    v1 = 16'hxxxx;
    v0 = 16'hxxxx;
    for (int i = 0; i < 4 * SD; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (bus1.digit_sel == (4'b0001 << k)) v1[k*4 +: 4] = bus1.bcd_out;
        if (bus0.digit_sel == (4'b0001 << k)) v0[k*4 +: 4] = bus0.bcd_out;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] v1, v0;
    logic [3:0] prev_sel, prev_bcd;
    int run, slots;
    bit seen;

    vecs[0] = '{sl: 7'd57,  sr: 7'd8,  exp1: 16'h57F8, exp0: 16'h5708};
    vecs[1] = '{sl: 7'd127, sr: 7'd99, exp1: 16'h9999, exp0: 16'h9999};
    vecs[2] = '{sl: 7'd10,  sr: 7'd0,  exp1: 16'h10F0, exp0: 16'h1000};
    vecs[3] = '{sl: 7'd9,   sr: 7'd90, exp1: 16'hF990, exp0: 16'h0990};
    vecs[4] = '{sl: 7'd0,   sr: 7'd0,  exp1: 16'hF0F0, exp0: 16'h0000};
    vecs[5] = '{sl: 7'd99,  sr: 7'd1,  exp1: 16'h99F1, exp0: 16'h9901};
    vecs[6] = '{sl: 7'd100, sr: 7'd64, exp1: 16'h9964, exp0: 16'h9964};

    drive(7'd0, 7'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {15'd0, bus1.busy}, 16'd0);
    check("rst_sel", {12'd0, bus1.digit_sel}, 16'h0001);
    check("rst_bcd", {12'd0, bus1.bcd_out}, 16'h0000);
    repeat (SD) @(negedge clk);
    check("slot1_sel", {12'd0, bus1.digit_sel}, 16'h0002);
    check("slot1_bcd_blank", {12'd0, bus1.bcd_out}, 16'h000F);
    check("slot1_bcd_noblank", {12'd0, bus0.bcd_out}, 16'h0000);

    for (int i = 0; i < 7; i++) begin
      convert(vecs[i].sl, vecs[i].sr, n);
      check("busy_len", 16'(n), 16'd8);
      capture(v1, v0);
      check("disp_blank", v1, vecs[i].exp1);
      check("disp_noblank", v0, vecs[i].exp0);
      $display("vec %0d: l=%0d r=%0d busy=%0d disp1=%h disp0=%h", i, vecs[i].sl, vecs[i].sr, n, v1, v0);
    end

    // Dropped request: second update three cycles into the conversion.
    @(negedge clk);
    drive(7'd42, 7'd42, 1'b1);
    @(negedge clk);
    drive(7'd42, 7'd42, 1'b0);
    n = 0;
    while (bus1.busy && n < 40) begin
      n++;
      @(negedge clk);
      drive(n == 2 ? 7'd13 : 7'd42, n == 2 ? 7'd13 : 7'd42, n == 2);
    end
    drive(7'd42, 7'd42, 1'b0);
    check("drop_busy_len", 16'(n), 16'd8);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus1.busy) seen = 1;
    end
    check("drop_no_requeue", {15'd0, seen}, 16'd0);
    capture(v1, v0);
    check("drop_disp", v1, 16'h4242);
    $display("drop: busy=%0d disp1=%h", n, v1);

    // Reset four cycles into SHIFT.
    @(negedge clk);
    drive(7'd77, 7'd77, 1'b1);
    @(negedge clk);
    drive(7'd77, 7'd77, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_busy_before", {15'd0, bus1.busy}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {15'd0, bus1.busy}, 16'd0);
    check("mid_rst_sel", {12'd0, bus1.digit_sel}, 16'h0001);
    check("mid_rst_bcd", {12'd0, bus1.bcd_out}, 16'h0000);
    capture(v1, v0);
    check("mid_disp_blank", v1, 16'hF0F0);
    check("mid_disp_noblank", v0, 16'h0000);
    convert(7'd25, 7'd3, n);
    check("post_busy_len", 16'(n), 16'd8);
    capture(v1, v0);
    check("post_disp_blank", v1, 16'h25F3);
    check("post_disp_noblank", v0, 16'h2503);
    $display("midrst: post busy=%0d disp1=%h disp0=%h", n, v1, v0);

    // Scan integrity over three rotations.
    @(negedge clk);
    prev_sel = bus1.digit_sel;
    prev_bcd = bus1.bcd_out;
    run = 1;
    slots = 0;
    seen = 0;
    for (int i = 0; i < 3 * 4 * SD + SD; i++) begin
      @(negedge clk);
      check("scan_onehot", {15'd0, $onehot(bus1.digit_sel)}, 16'd1);
      check("scan_bcd_sync", {15'd0, (bus1.digit_sel == prev_sel) && (bus1.bcd_out != prev_bcd)}, 16'd0);
      if (bus1.digit_sel != prev_sel) begin
        check("scan_rotate", {12'd0, bus1.digit_sel}, {12'd0, prev_sel[2:0], prev_sel[3]});
        if (seen) begin
          check("scan_slot_len", 16'(run), 16'(SD));
          slots++;
        end
        seen = 1;
        run = 1;
      end else begin
        run++;
      end
      prev_sel = bus1.digit_sel;
      prev_bcd = bus1.bcd_out;
    end
    check("scan_slots", 16'(slots >= 11), 16'd1);
    $display("scan: slots=%0d", slots);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
